rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: A (ALU result) and B (memory load return).
- Each source has its own DEPTH-entry FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFO heads into a registered write stage that drives DstReg, WriteReg and DstData of the register file.
- A per-register busy vector tells the hazard logic which registers still have writes in flight.

---
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two result sources and the register-file write port.
// Carries both source handshakes, the write-port outputs and the busy vector.
interface rf_write_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic                 a_valid;
  logic                 a_ready;
  logic [AW-1:0]        a_reg;
  logic [DW-1:0]        a_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [AW-1:0]        b_reg;
  logic [DW-1:0]        b_data;
  logic [AW-1:0]        DstReg;
  logic                 WriteReg;
  logic [DW-1:0]        DstData;
  logic [(1<<AW)-1:0]   busy;

  // Producer side: the sources and whoever watches the register-file port.
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, DstReg, WriteReg, DstData, busy
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, DstReg, WriteReg, DstData, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two per-source FIFOs (A = ALU, B = load
// return) drained round-robin into a registered write stage, plus a busy
// vector marking every register that still has a write queued or staged.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave wb
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int NR = 1 << AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam int SA = 0;
  localparam int SB = 1;

  // Source-indexed views of the two input ports
  logic [1:0]    in_valid;
  logic [AW-1:0] in_reg  [2];
  logic [DW-1:0] in_data [2];

  assign in_valid    = {wb.b_valid, wb.a_valid};
  assign in_reg[SA]  = wb.a_reg;
  assign in_reg[SB]  = wb.b_reg;
  assign in_data[SA] = wb.a_data;
  assign in_data[SB] = wb.b_data;

  // FIFO control and storage
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];
  logic [AW-1:0] reg_mem_q  [2][DEPTH];
  logic [AW-1:0] reg_mem_d  [2][DEPTH];
  logic [DW-1:0] data_mem_q [2][DEPTH];
  logic [DW-1:0] data_mem_d [2][DEPTH];

  // Arbiter pointer: 1 means B was granted last, so A wins the next conflict
  logic last_b_q;
  logic last_b_d;

  // Write stage
  logic          wr_en_q;
  logic          wr_en_d;
  logic [AW-1:0] dst_reg_q;
  logic [AW-1:0] dst_reg_d;
  logic [DW-1:0] dst_data_q;
  logic [DW-1:0] dst_data_d;

  logic [1:0]    rdy;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    not_empty;
  logic [1:0]    grant;
  logic [NR-1:0] busy_c;

  // Ready and push qualification from registered occupancy only; held low in reset
  always_comb begin
    rdy       = '0;
    push      = '0;
    not_empty = '0;
    for (int s = 0; s < 2; s++) begin
      not_empty[s] = (cnt_q[s] != '0);
      rdy[s]       = rst && (cnt_q[s] < FULL);
      push[s]      = in_valid[s] && rdy[s];
    end
  end

  // Round-robin grant over the FIFO heads; pointer moves only on a grant
  always_comb begin
    grant     = '0;
    grant[SA] = not_empty[SA] && (!not_empty[SB] || last_b_q);
    grant[SB] = not_empty[SB] && (!not_empty[SA] || !last_b_q);
    pop       = grant;
    last_b_d  = last_b_q;
    if (grant[SA]) begin
      last_b_d = 1'b0;
    end else if (grant[SB]) begin
      last_b_d = 1'b1;
    end
  end

  // FIFO pointer/count/storage next state; push and pop may coincide
  always_comb begin
    reg_mem_d  = reg_mem_q;
    data_mem_d = data_mem_q;
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PW'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      if (push[s]) begin
        reg_mem_d[s][wr_ptr_q[s]]  = in_reg[s];
        data_mem_d[s][wr_ptr_q[s]] = in_data[s];
      end
    end
  end

  // Write stage: load the granted head, otherwise drop the enable and hold
  always_comb begin
    wr_en_d    = |grant;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    if (grant[SA]) begin
      dst_reg_d  = reg_mem_q[SA][rd_ptr_q[SA]];
      dst_data_d = data_mem_q[SA][rd_ptr_q[SA]];
    end else if (grant[SB]) begin
      dst_reg_d  = reg_mem_q[SB][rd_ptr_q[SB]];
      dst_data_d = data_mem_q[SB][rd_ptr_q[SB]];
    end
  end

  // Busy: every occupied FIFO slot plus the staged write marks its register
  always_comb begin
    logic [PW-1:0] offs;
    busy_c = '0;
    offs   = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs = PW'(i) - rd_ptr_q[s];
        if (CW'(offs) < cnt_q[s]) begin
          busy_c[reg_mem_q[s][i]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      busy_c[dst_reg_q] = 1'b1;
    end
  end

  // Control and write-stage registers; reset discards queued and staged writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      last_b_q   <= 1'b1;
      wr_en_q    <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      last_b_q   <= last_b_d;
      wr_en_q    <= wr_en_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
    end
  end

  // FIFO payload storage; validity is tracked by the counts, so no reset
  always_ff @(posedge clk) begin
    reg_mem_q  <= reg_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign wb.a_ready  = rdy[SA];
  assign wb.b_ready  = rdy[SB];
  assign wb.WriteReg = wr_en_q;
  assign wb.DstReg   = dst_reg_q;
  assign wb.DstData  = dst_data_q;
  assign wb.busy     = busy_c;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: table-driven back-pressure sequence
// plus hand-written reset, single-write, conflict, wrap and aliasing cases.
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.AW(4), .DW(16)) wb ();

  rf_write_arbiter #(.DEPTH(2), .AW(4), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  br;
    logic [15:0] bd;
    logic        e_ard;
    logic        e_brd;
    logic        e_we;
    logic [3:0]  e_dr;
    logic [15:0] e_dd;
    logic [15:0] e_busy;
  } vec_t;

  vec_t tbl [11];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [3:0] br, input logic [15:0] bd);
    wb.a_valid = av; wb.a_reg = ar; wb.a_data = ad;
    wb.b_valid = bv; wb.b_reg = br; wb.b_data = bd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [3:0] dr,
                         input logic [15:0] dd, input logic [15:0] bz);
    chk({tag, ".WriteReg"}, 32'(wb.WriteReg), 32'(we));
    chk({tag, ".DstReg"},   32'(wb.DstReg),   32'(dr));
    chk({tag, ".DstData"},  32'(wb.DstData),  32'(dd));
    chk({tag, ".busy"},     32'(wb.busy),     32'(bz));
  endtask

  task automatic chk_rdy(input string tag, input logic ar, input logic br);
    chk({tag, ".a_ready"}, 32'(wb.a_ready), 32'(ar));
    chk({tag, ".b_ready"}, 32'(wb.b_ready), 32'(br));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                              input logic bv, input logic [3:0] br, input logic [15:0] bd,
                              input logic ea, input logic eb, input logic we,
                              input logic [3:0] dr, input logic [15:0] dd, input logic [15:0] bz);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.e_ard = ea; v.e_brd = eb; v.e_we = we; v.e_dr = dr; v.e_dd = dd; v.e_busy = bz;
    return v;
  endfunction

  initial begin
    // A holds each word until accepted; B offers three words. Expected values
    // are the state seen just after each edge.
    tbl[0]  = mk(1'b1, 4'd1, 16'h0001, 1'b1, 4'd8,  16'hB001, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0102);
    tbl[1]  = mk(1'b1, 4'd2, 16'h0002, 1'b1, 4'd9,  16'hB002, 1'b1, 1'b0, 1'b1, 4'd1,  16'h0001, 16'h0306);
    tbl[2]  = mk(1'b1, 4'd3, 16'h0003, 1'b1, 4'd10, 16'hB003, 1'b0, 1'b1, 1'b1, 4'd8,  16'hB001, 16'h030C);
    tbl[3]  = mk(1'b1, 4'd4, 16'h0004, 1'b1, 4'd10, 16'hB003, 1'b1, 1'b0, 1'b1, 4'd2,  16'h0002, 16'h060C);
    tbl[4]  = mk(1'b1, 4'd4, 16'h0004, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 4'd9,  16'hB002, 16'h0618);
    tbl[5]  = mk(1'b1, 4'd5, 16'h0005, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0003, 16'h0418);
    tbl[6]  = mk(1'b1, 4'd5, 16'h0005, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 4'd10, 16'hB003, 16'h0430);
    tbl[7]  = mk(1'b1, 4'd6, 16'h0006, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b1, 4'd4,  16'h0004, 16'h0030);
    tbl[8]  = mk(1'b1, 4'd6, 16'h0006, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b1, 4'd5,  16'h0005, 16'h0060);
    tbl[9]  = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b1, 4'd6,  16'h0006, 16'h0040);
    tbl[10] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 4'd6,  16'h0006, 16'h0000);

    // Reset then idle
    idle();
    rst = 1'b0;
    #12;
    chk_rdy("in_reset", 1'b0, 1'b0);
    chk("in_reset.WriteReg", 32'(wb.WriteReg), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk_rdy("after_reset", 1'b1, 1'b1);
    chk_out("after_reset", 1'b0, 4'd0, 16'h0000, 16'h0000);

    // Single write: push at E0, write visible E1..E2
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000);
    step();
    idle();
    chk_out("single.E0", 1'b0, 4'd0, 16'h0000, 16'h0008);
    step();
    chk_out("single.E1", 1'b1, 4'd3, 16'h1234, 16'h0008);
    step();
    chk_out("single.E2", 1'b0, 4'd3, 16'h1234, 16'h0000);

    // Conflict, twice: A then B each time
    do_reset();
    drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB);
    step();
    idle();
    chk_out("conf.E0", 1'b0, 4'd0, 16'h0000, 16'h0060);
    step();
    chk_out("conf.E1", 1'b1, 4'd5, 16'hAAAA, 16'h0060);
    step();
    chk_out("conf.E2", 1'b1, 4'd6, 16'hBBBB, 16'h0040);
    drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB);
    step();
    idle();
    chk_out("conf.E3", 1'b0, 4'd6, 16'hBBBB, 16'h0060);
    step();
    chk_out("conf.E4", 1'b1, 4'd5, 16'hAAAA, 16'h0060);
    step();
    chk_out("conf.E5", 1'b1, 4'd6, 16'hBBBB, 16'h0040);
    step();
    chk_out("conf.E6", 1'b0, 4'd6, 16'hBBBB, 16'h0000);

    // Full and back-pressure, table driven
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].av, tbl[k].ar, tbl[k].ad, tbl[k].bv, tbl[k].br, tbl[k].bd);
      step();
      chk_rdy($sformatf("bp[%0d]", k), tbl[k].e_ard, tbl[k].e_brd);
      chk_out($sformatf("bp[%0d]", k), tbl[k].e_we, tbl[k].e_dr, tbl[k].e_dd, tbl[k].e_busy);
    end
    idle();

    // Wrap: ten back-to-back writes through A
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 4'd0, 16'h0000);
      step();
      chk_rdy($sformatf("wrap[%0d]", i), 1'b1, 1'b1);
      if (i == 0) begin
        chk_out("wrap[0]", 1'b0, 4'd0, 16'h0000, 16'h0001);
      end else begin
        chk_out($sformatf("wrap[%0d]", i), 1'b1, 4'(i - 1), 16'(16'h0100 + i - 1),
                16'((1 << i) | (1 << (i - 1))));
      end
    end
    idle();
    step();
    chk_out("wrap.last", 1'b1, 4'd9, 16'h0109, 16'h0200);
    step();
    chk_out("wrap.done", 1'b0, 4'd9, 16'h0109, 16'h0000);

    // Busy aliasing: both sources target register 7
    do_reset();
    drive(1'b1, 4'd7, 16'h007A, 1'b1, 4'd7, 16'h007B);
    step();
    idle();
    chk_out("alias.E0", 1'b0, 4'd0, 16'h0000, 16'h0080);
    step();
    chk_out("alias.E1", 1'b1, 4'd7, 16'h007A, 16'h0080);
    step();
    chk_out("alias.E2", 1'b1, 4'd7, 16'h007B, 16'h0080);
    step();
    chk_out("alias.E3", 1'b0, 4'd7, 16'h007B, 16'h0000);

    // Reset mid-operation with both FIFOs loaded and a write staged
    do_reset();
    drive(1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022);
    step();
    drive(1'b1, 4'd3, 16'h0033, 1'b1, 4'd4, 16'h0044);
    step();
    idle();
    chk_out("mid.loaded", 1'b1, 4'd1, 16'h0011, 16'h001E);
    #2;
    rst = 1'b0;
    #1;
    chk_out("mid.in_reset", 1'b0, 4'd0, 16'h0000, 16'h0000);
    chk_rdy("mid.in_reset", 1'b0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk_rdy("mid.released", 1'b1, 1'b1);
    step();
    chk_out("mid.after1", 1'b0, 4'd0, 16'h0000, 16'h0000);
    step();
    chk_out("mid.after2", 1'b0, 4'd0, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
